spi_slave_sequencer: RTL and testbench
======================================

# spi_slave_sequencer

System-clock sequencer for the SPI memory slave datapath: shift register, address latch, data memory and MISO tri-state buffer. It consumes conditioned chip-select and single-cycle SCLK edge pulses from the input conditioners. It counts the header and data bits, and issues the one-cycle load and write strobes that make the datapath perform a read or a write. It replaces per-SCLK control with a single-clock design that has defined reset and abort behaviour.

## Interface
- WIDTH, 8, bits per header (7 address + 1 R/W) and per data word
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- cs_cond  in  1  conditioned chip select, active-low (1 = idle)
- sclk_pos  in  1  one-clk pulse per conditioned SCLK rising edge
- sclk_neg  in  1  one-clk pulse per conditioned SCLK falling edge (used only by datapath; ignored here except as noted)
- rw_bit  in  1  shift register parallel-out bit 0; 1 = read, 0 = write
- sr_we  out  1  shift register parallel-load enable
- addr_we  out  1  address latch enable
- dm_we  out  1  data memory write enable
- miso_buf_en  out  1  MISO tri-state enable
- busy  out  1  high whenever state != IDLE
- frame_err  out  1  one-clk pulse: transaction aborted by cs_cond rising early

## Operation
- Bit counter width $clog2(WIDTH+1); cleared on every state change.
- States and transitions:
  - IDLE: cs_cond = 0 goes to GET_ADDR.
  - GET_ADDR: count sclk_pos. A pulse arriving with count = WIDTH-1 goes to GOT_ADDR.
  - GOT_ADDR (1 clk): addr_we = 1. Sample rw_bit: 1 goes to READ_WAIT, 0 goes to WRITE_SHIFT.
  - READ_WAIT (1 clk): covers the 1-cycle synchronous memory read. Goes to READ_LOAD.
  - READ_LOAD (1 clk): sr_we = 1, miso_buf_en = 1. Goes to READ_SHIFT.
  - READ_SHIFT: miso_buf_en = 1. Count sclk_pos; the WIDTH-th pulse goes to DONE.
  - WRITE_SHIFT: count sclk_pos; the WIDTH-th pulse goes to WRITE_COMMIT.
  - WRITE_COMMIT (1 clk): dm_we = 1. Goes to DONE.
  - DONE: all strobes 0. cs_cond = 1 goes to IDLE.
- Outputs are Moore-decoded from the state register; no glitches on input changes.
- Abort rule: cs_cond = 1 in any state other than IDLE, DONE or WRITE_COMMIT:
  - next state is IDLE, counter cleared;
  - frame_err = 1 for the following cycle only.
- WRITE_COMMIT always completes, because all data bits have been received. cs_cond = 1 during it goes to IDLE with no frame_err.
- Ignored inputs:
  - sclk_pos in IDLE, GOT_ADDR, READ_WAIT, READ_LOAD, WRITE_COMMIT and DONE;
  - sclk_pos in the same cycle as an abort;
  - sclk_neg always.
- Reset outputs: sr_we, addr_we, dm_we, miso_buf_en, busy and frame_err all 0; state IDLE; counter 0.
- reset overrides all inputs, including mid-transaction. No frame_err is generated by reset.

## Timing
- addr_we: high exactly 1 clk, in the cycle after the clk carrying the WIDTH-th header sclk_pos.
- sr_we: high 3 clks after that sclk_pos (GOT_ADDR, then READ_WAIT, then READ_LOAD).
- miso_buf_en:
  - rises with sr_we;
  - falls in the cycle after the clk carrying the WIDTH-th data sclk_pos.
- dm_we: high exactly 1 clk, in the cycle after the clk carrying the WIDTH-th data sclk_pos.
- Requirement on the master: SCLK half-period ≥ 4 clk. This guarantees the read load completes before the first data sclk_neg.
- busy: rises 1 clk after cs_cond falls; falls 1 clk after cs_cond rises.
- Back-to-back transactions: a new transaction is accepted when cs_cond falls, from the first cycle spent in IDLE.

## Test plan
- Write: cs low, header 0x54 (addr 0x2A, rw = 0) then data 0xC3, SCLK half-period 4 clk → addr_we 1 clk after 8th pulse; no sr_we; dm_we 1 clk after 16th pulse; DONE until cs high, then IDLE.
- Read: header 0x55 (rw = 1) → addr_we, then sr_we 2 clks later with miso_buf_en rising together; 8 more sclk_pos; miso_buf_en falls 1 clk after the 16th; dm_we never asserted.
- Abort: cs high after 5 header pulses → IDLE next clk, frame_err 1 clk, no strobes. Repeat with cs high after 3 read-data pulses → same response, miso_buf_en low next clk.
- Reset mid-WRITE_SHIFT after 4 data pulses → next clk all outputs 0, busy 0, frame_err 0; a fresh write then completes normally.
- Extra clocks: 3 extra sclk_pos in DONE → ignored, no strobes. cs high coincident with WRITE_COMMIT → dm_we still 1 clk, no frame_err.
- Back-to-back: write then read separated by one IDLE clk with cs high → both complete; strobe counts are exactly 1 addr_we each, 1 dm_we and 1 sr_we.

Source files
------------

// File: rtl/spi_slave_sequencer.sv
// spi_slave_sequencer: system-clock control FSM for the SPI memory slave datapath.
// Counts header and data bits from conditioned SCLK edge pulses and issues the
// one-cycle load/write strobes for the shift register, address latch and data
// memory, plus the MISO tri-state enable. All outputs are registered and
// Moore-decoded from the next-state value, so they track the state register
// exactly and never glitch on input changes.

module spi_slave_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_cond,
  input  logic sclk_pos,
  input  logic sclk_neg,
  input  logic rw_bit,
  output logic sr_we,
  output logic addr_we,
  output logic dm_we,
  output logic miso_buf_en,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StGotAddr,
    StReadWait,
    StReadLoad,
    StReadShift,
    StWriteShift,
    StWriteCommit,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sr_we_q, sr_we_d;
  logic            addr_we_q, addr_we_d;
  logic            dm_we_q, dm_we_d;
  logic            miso_buf_en_q, miso_buf_en_d;
  logic            busy_q, busy_d;
  logic            frame_err_q, frame_err_d;

  logic abortable;
  logic abort;
  logic count_en;

  // SCLK falling edges only matter to the datapath.
  logic unused_sclk_neg;
  assign unused_sclk_neg = sclk_neg;

  // States in which cs_cond rising means the master gave up mid-frame.
  always_comb begin
    abortable = 1'b0;
    unique case (state_q)
      StGetAddr, StGotAddr, StReadWait, StReadLoad, StReadShift, StWriteShift: abortable = 1'b1;
      default: abortable = 1'b0;
    endcase
  end

  assign abort = abortable & cs_cond;

  // Next-state logic; an abort overrides every normal transition and any sclk_pos.
  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!cs_cond) state_d = StGetAddr;
      end
      StGetAddr: begin
        if (sclk_pos) begin
          if (cnt_q == LastBit) state_d = StGotAddr;
          else                  count_en = 1'b1;
        end
      end
      StGotAddr: begin
        state_d = rw_bit ? StReadWait : StWriteShift;
      end
      StReadWait: begin
        state_d = StReadLoad;
      end
      StReadLoad: begin
        state_d = StReadShift;
      end
      StReadShift: begin
        if (sclk_pos) begin
          if (cnt_q == LastBit) state_d = StDone;
          else                  count_en = 1'b1;
        end
      end
      StWriteShift: begin
        if (sclk_pos) begin
          if (cnt_q == LastBit) state_d = StWriteCommit;
          else                  count_en = 1'b1;
        end
      end
      StWriteCommit: begin
        // All data bits are in, so the commit always happens; cs high just skips DONE.
        state_d = cs_cond ? StIdle : StDone;
      end
      StDone: begin
        if (cs_cond) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort) begin
      state_d  = StIdle;
      count_en = 1'b0;
    end
  end

  // Bit counter restarts from zero on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (count_en)      cnt_d = cnt_q + CntW'(1);
  end

  // Output decode from the next state so registered outputs line up with state_q.
  always_comb begin
    sr_we_d       = 1'b0;
    addr_we_d     = 1'b0;
    dm_we_d       = 1'b0;
    miso_buf_en_d = 1'b0;
    busy_d        = (state_d != StIdle);
    frame_err_d   = abort;
    unique case (state_d)
      StGotAddr: begin
        addr_we_d = 1'b1;
      end
      StReadLoad: begin
        sr_we_d       = 1'b1;
        miso_buf_en_d = 1'b1;
      end
      StReadShift: begin
        miso_buf_en_d = 1'b1;
      end
      StWriteCommit: begin
        dm_we_d = 1'b1;
      end
      default: begin
        sr_we_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      sr_we_q       <= 1'b0;
      addr_we_q     <= 1'b0;
      dm_we_q       <= 1'b0;
      miso_buf_en_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sr_we_q       <= sr_we_d;
      addr_we_q     <= addr_we_d;
      dm_we_q       <= dm_we_d;
      miso_buf_en_q <= miso_buf_en_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign sr_we       = sr_we_q;
  assign addr_we     = addr_we_q;
  assign dm_we       = dm_we_q;
  assign miso_buf_en = miso_buf_en_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// Testbench for spi_slave_sequencer. Directed frames are driven with SCLK
// half-period 4 clk; every expected output event (strobe cycle, busy/miso edge)
// is predicted with its cycle number and queued, and a negedge monitor matches
// each observed event against the queue.

module tb_spi_slave_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int Period = 8;  // clk cycles per SCLK period

  localparam int EvBusyRise = 0;
  localparam int EvBusyFall = 1;
  localparam int EvAddr     = 2;
  localparam int EvSr       = 3;
  localparam int EvDm       = 4;
  localparam int EvFerr     = 5;
  localparam int EvMisoRise = 6;
  localparam int EvMisoFall = 7;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic reset;
  logic cs_cond;
  logic sclk_pos;
  logic sclk_neg;
  logic rw_bit;
  logic sr_we;
  logic addr_we;
  logic dm_we;
  logic miso_buf_en;
  logic busy;
  logic frame_err;

  ev_t             exp_q[$];
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  bit              mon_en = 1'b0;
  logic [WIDTH-1:0] sr_model = '0;

  spi_slave_sequencer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cs_cond    (cs_cond),
    .sclk_pos   (sclk_pos),
    .sclk_neg   (sclk_neg),
    .rw_bit     (rw_bit),
    .sr_we      (sr_we),
    .addr_we    (addr_we),
    .dm_we      (dm_we),
    .miso_buf_en(miso_buf_en),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic string ev_name(input int k);
    case (k)
      EvBusyRise: return "busy_rise";
      EvBusyFall: return "busy_fall";
      EvAddr:     return "addr_we";
      EvSr:       return "sr_we";
      EvDm:       return "dm_we";
      EvFerr:     return "frame_err";
      EvMisoRise: return "miso_rise";
      EvMisoFall: return "miso_fall";
      default:    return "unknown";
    endcase
  endfunction

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Pop the queued prediction for an observed event; anything unpredicted is a failure.
  task automatic match_event(input int kind);
    int idx;
    idx = -1;
    n_checks++;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].cyc == cyc) idx = i;
    end
    if (idx >= 0) begin
      exp_q.delete(idx);
    end else begin
      n_fail++;
      $display("FAIL %s at cycle %0d: observed 1, expected 0 (no event predicted here)",
               ev_name(kind), cyc);
    end
  endtask

  task automatic check_bit(input string what, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", what, got, want);
    end
  endtask

  // Monitor: every strobe-high cycle and every busy/miso edge is one event.
  initial begin
    logic busy_prev;
    logic miso_prev;
    busy_prev = 1'b0;
    miso_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy && !busy_prev)        match_event(EvBusyRise);
        if (!busy && busy_prev)        match_event(EvBusyFall);
        if (addr_we)                   match_event(EvAddr);
        if (sr_we)                     match_event(EvSr);
        if (dm_we)                     match_event(EvDm);
        if (frame_err)                 match_event(EvFerr);
        if (miso_buf_en && !miso_prev) match_event(EvMisoRise);
        if (!miso_buf_en && miso_prev) match_event(EvMisoFall);
      end
      busy_prev = busy;
      miso_prev = miso_buf_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SCLK period: rising-edge pulse now, falling-edge pulse half a period later.
  task automatic sclk_cycle(input logic b);
    sr_model = {sr_model[WIDTH-2:0], b};
    rw_bit   = sr_model[0];
    sclk_pos = 1'b1;
    tick();
    sclk_pos = 1'b0;
    tick(); tick(); tick();
    sclk_neg = 1'b1;
    tick();
    sclk_neg = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) sclk_cycle(v[7-i]);
  endtask

  task automatic start_frame();
    cs_cond = 1'b0;
    push_ev(EvBusyRise, cyc + 1);
    tick(); tick();
  endtask

  task automatic end_frame();
    cs_cond = 1'b1;
    push_ev(EvBusyFall, cyc + 1);
    tick();
  endtask

  initial begin
    ev_t e;
    int  p;
    int  q;

    reset    = 1'b1;
    cs_cond  = 1'b1;
    sclk_pos = 1'b0;
    sclk_neg = 1'b0;
    rw_bit   = 1'b0;
    repeat (3) tick();

    check_bit("reset sr_we", sr_we, 1'b0);
    check_bit("reset addr_we", addr_we, 1'b0);
    check_bit("reset dm_we", dm_we, 1'b0);
    check_bit("reset miso_buf_en", miso_buf_en, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset frame_err", frame_err, 1'b0);

    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();

    // Write 0x2A <- 0xC3, then 3 stray pulses in DONE.
    start_frame();
    p = cyc + Period * (WIDTH - 1);
    push_ev(EvAddr, p + 1);
    send_bits(8'h54, 8);
    q = cyc + Period * (WIDTH - 1);
    push_ev(EvDm, q + 1);
    send_bits(8'hC3, 8);
    send_bits(8'hFF, 3);
    end_frame();

    // Back-to-back read: cs goes low in the first IDLE cycle.
    start_frame();
    p = cyc + Period * (WIDTH - 1);
    push_ev(EvAddr, p + 1);
    push_ev(EvSr, p + 3);
    push_ev(EvMisoRise, p + 3);
    send_bits(8'h55, 8);
    q = cyc + Period * (WIDTH - 1);
    push_ev(EvMisoFall, q + 1);
    send_bits(8'hA5, 8);
    end_frame();
    repeat (3) tick();

    // Abort after 5 header pulses.
    start_frame();
    send_bits(8'h3C, 5);
    cs_cond = 1'b1;
    push_ev(EvFerr, cyc + 1);
    push_ev(EvBusyFall, cyc + 1);
    tick(); tick(); tick();

    // Abort after 3 read-data pulses, with a coincident sclk_pos that must be ignored.
    start_frame();
    p = cyc + Period * (WIDTH - 1);
    push_ev(EvAddr, p + 1);
    push_ev(EvSr, p + 3);
    push_ev(EvMisoRise, p + 3);
    send_bits(8'h55, 8);
    send_bits(8'h00, 3);
    cs_cond  = 1'b1;
    sclk_pos = 1'b1;
    push_ev(EvFerr, cyc + 1);
    push_ev(EvMisoFall, cyc + 1);
    push_ev(EvBusyFall, cyc + 1);
    tick();
    sclk_pos = 1'b0;
    tick(); tick();

    // Reset in WRITE_SHIFT after 4 data pulses.
    start_frame();
    p = cyc + Period * (WIDTH - 1);
    push_ev(EvAddr, p + 1);
    send_bits(8'h54, 8);
    send_bits(8'hC3, 4);
    reset   = 1'b1;
    cs_cond = 1'b1;
    push_ev(EvBusyFall, cyc + 1);
    tick();
    check_bit("mid-reset sr_we", sr_we, 1'b0);
    check_bit("mid-reset addr_we", addr_we, 1'b0);
    check_bit("mid-reset dm_we", dm_we, 1'b0);
    check_bit("mid-reset miso_buf_en", miso_buf_en, 1'b0);
    check_bit("mid-reset busy", busy, 1'b0);
    check_bit("mid-reset frame_err", frame_err, 1'b0);
    reset = 1'b0;
    tick(); tick();

    // Fresh write; cs rises during WRITE_COMMIT, commit still happens without frame_err.
    start_frame();
    p = cyc + Period * (WIDTH - 1);
    push_ev(EvAddr, p + 1);
    send_bits(8'h54, 8);
    send_bits(8'hC3, 7);
    q = cyc;
    push_ev(EvDm, q + 1);
    push_ev(EvBusyFall, q + 2);
    sr_model = {sr_model[WIDTH-2:0], 1'b1};
    rw_bit   = sr_model[0];
    sclk_pos = 1'b1;
    tick();
    sclk_pos = 1'b0;
    cs_cond  = 1'b1;
    tick();

    repeat (20) tick();

    // Predictions never observed.
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s at cycle %0d: observed 0, expected 1", ev_name(e.kind), e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
